kt8_debug_ctrl: RTL

Debug/host controller for the KT8 core. It owns the 32-byte data RAM port and the core's hold and reset lines, and lets an external host halt, resume, single-step and reset the CPU. While the CPU is frozen, the host can read or write data RAM through a valid/ready command channel. It sits between the CPU's RAM port and the RAM macro, beside the CPU clock gate.

---
 rtl/kt8_dbg_pkg.sv | 34 +++
 rtl/kt8_ram_mux.sv | 31 +++
 rtl/kt8_debug_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/kt8_dbg_pkg.sv
// Shared widths, host command codes and controller state encoding for the
// KT8 debug controller.
package kt8_dbg_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'd0,
      CMD_HALT  = 3'd1,
      CMD_RUN   = 3'd2,
      CMD_STEP  = 3'd3,
      CMD_READ  = 3'd4,
      CMD_WRITE = 3'd5,
      CMD_RESET = 3'd6,
      CMD_RSVD  = 3'd7
   } cmd_e;

   typedef enum logic [2:0] {
      ST_RST,
      ST_RUN,
      ST_HALTED,
      ST_SYNC,
      ST_ACCESS,
      ST_STEP,
      ST_RESP
   } state_e;

   // Idle state the controller rests in for a given home setting.
   function automatic state_e home_state(input logic home_halted);
      return home_halted ? ST_HALTED : ST_RUN;
   endfunction

endpackage

// File: rtl/kt8_ram_mux.sv
// Data RAM port select: CPU pass-through, host access, and CPU write blocking
// while the host owns the RAM.
module kt8_ram_mux
   import kt8_dbg_pkg::*;
(
   input  logic              sel_host,
   input  logic              block_cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   input  logic              host_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      ram_addr = cpu_addr;
      ram_data = cpu_data;
      ram_we   = cpu_we && !block_cpu_we;
      if (sel_host) begin
         ram_addr = host_addr;
         ram_data = host_data;
         ram_we   = host_we;
      end
   end

endmodule

// File: rtl/kt8_debug_ctrl.sv
// Host debug controller for the KT8 core: halt/run/step/reset control and
// host access to data RAM while the CPU clock is held.
module kt8_debug_ctrl
   import kt8_dbg_pkg::*;
#(
   parameter bit          BOOT_HALTED = 1'b0,
   parameter int unsigned RST_CYCLES  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              host_valid_i,
   output logic              host_ready_o,
   input  logic [2:0]        host_cmd_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              halted_o,
   output logic              cpu_hold_o,
   output logic              cpu_rst_o,
   input  logic [ADDR_W-1:0] cpu_ram_address_i,
   input  logic [DATA_W-1:0] cpu_ram_data_i,
   input  logic              cpu_ram_we_i,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_data_o,
   output logic              ram_we_o
);

   state_e            state;
   logic              home_halted;
   logic [3:0]        rst_cnt;
   logic              rst_by_cmd;
   logic              is_write;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign host_ready_o = (state == ST_RUN) || (state == ST_HALTED);
   assign halted_o     = home_halted;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_RST;
         home_halted <= BOOT_HALTED;
         rst_cnt     <= 4'(RST_CYCLES);
         rst_by_cmd  <= 1'b0;
         is_write    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         cpu_hold_o  <= 1'b1;
         cpu_rst_o   <= 1'b1;
      end else begin
         // NOTE: all state here uses <= so every register samples pre-edge values.
         rsp_valid_o <= 1'b0;
         unique case (state)
            ST_RST: begin
               if (rst_cnt <= 4'd1) begin
                  state       <= home_state(home_halted);
                  cpu_rst_o   <= 1'b0;
                  cpu_hold_o  <= home_halted;
                  rsp_valid_o <= rst_by_cmd;
                  rst_by_cmd  <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt - 4'd1;
               end
            end
            ST_RUN, ST_HALTED: begin
               if (host_valid_i) begin
                  is_write   <= (cmd_e'(host_cmd_i) == CMD_WRITE);
                  addr_q     <= host_addr_i;
                  wdata_q    <= host_wdata_i;
                  rsp_data_o <= '0;
                  unique case (cmd_e'(host_cmd_i))
                     CMD_HALT: begin
                        home_halted <= 1'b1;
                        cpu_hold_o  <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                     end
                     CMD_RUN: begin
                        home_halted <= 1'b0;
                        cpu_hold_o  <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                     end
                     CMD_STEP: begin
                        if (state == ST_HALTED) begin
                           cpu_hold_o <= 1'b0;
                           state      <= ST_STEP;
                        end else begin
                           home_halted <= 1'b1;
                           cpu_hold_o  <= 1'b1;
                           rsp_valid_o <= 1'b1;
                           state       <= ST_RESP;
                        end
                     end
                     CMD_READ, CMD_WRITE: begin
                        cpu_hold_o <= 1'b1;
                        state      <= ST_SYNC;
                     end
                     CMD_RESET: begin
                        rst_cnt    <= 4'(RST_CYCLES);
                        rst_by_cmd <= 1'b1;
                        cpu_rst_o  <= 1'b1;
                        cpu_hold_o <= 1'b1;
                        state      <= ST_RST;
                     end
                     default: begin
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_SYNC: state <= ST_ACCESS;
            ST_ACCESS: begin
               // Read data is sampled from the asynchronous RAM at the end of ACCESS.
               rsp_data_o  <= is_write ? wdata_q : ram_rdata_i;
               rsp_valid_o <= 1'b1;
               cpu_hold_o  <= home_halted;
               state       <= ST_RESP;
            end
            ST_STEP: begin
               rsp_valid_o <= 1'b1;
               cpu_hold_o  <= home_halted;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               cpu_hold_o <= home_halted;
               state      <= home_state(home_halted);
            end
            default: state <= ST_RST;
         endcase
      end
   end

   kt8_ram_mux u_ram_mux (
      .sel_host     (state == ST_ACCESS),
      .block_cpu_we ((state == ST_SYNC) || (state == ST_ACCESS)),
      .cpu_addr     (cpu_ram_address_i),
      .cpu_data     (cpu_ram_data_i),
      .cpu_we       (cpu_ram_we_i),
      .host_addr    (addr_q),
      .host_data    (wdata_q),
      .host_we      (is_write),
      .ram_addr     (ram_address_o),
      .ram_data     (ram_data_o),
      .ram_we       (ram_we_o)
   );

endmodule
